// File: rtl/catv_pkg.sv
// Shared types for the catv_riscv instruction-fetch front end.
package catv_pkg;

  localparam int INSN_BYTES = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] insn;
  } fetch_entry_t;

  typedef enum logic {
    ST_BOOT,
    ST_FETCH
  } fetch_state_e;

endpackage

// File: rtl/catv_fifo.sv
// Small circular FIFO with synchronous flush; flush beats a same-cycle push.
module catv_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0]
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  T                             push_data,
  input  logic                         pop,
  output T                             pop_data,
  input  logic                         flush,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) push |-> !full);

endmodule

// File: rtl/catv_prefetch_buffer.sv
// Instruction prefetch buffer: sequential word fetch from BOOT_ADDR, FIFO of
// {pc, insn} toward decode, flush-and-redirect on branch.
module catv_prefetch_buffer
  import catv_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0180,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_enable_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_addr_o,
  output logic [31:0] insn_addr_o,
  output logic        insn_valid_o,
  input  logic        insn_ready_i,
  input  logic [31:0] insn_data_i,
  input  logic        insn_rvalid_i,
  output logic        busy_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_addr_q, pc_q;
  logic          outstanding_q, discard_q;
  logic [CW-1:0] count;
  logic [CW:0]   used;
  logic          full, empty, pop, push, rsp, req, handshake, credit_ok;
  fetch_entry_t  push_entry, head;
  logic          unused_branch_lsbs;

  assign unused_branch_lsbs = ^branch_addr_i[1:0];

  // Credit: entries held plus the one in flight, minus what decode takes now.
  assign pop       = ~empty & instr_ready_i;
  assign used      = {1'b0, count} + (CW+1)'(outstanding_q) - (CW+1)'(pop);
  assign credit_ok = used < (CW+1)'(FIFO_DEPTH);

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: req = fetch_enable_i & ~branch_i & credit_ok;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  assign insn_valid_o = req;
  assign insn_addr_o  = req ? {fetch_addr_q[31:2], 2'b00} : 32'h0;
  assign handshake    = req & insn_ready_i;

  // rvalid is only meaningful when we actually have a request in flight.
  assign rsp        = insn_rvalid_i & outstanding_q;
  assign push       = rsp & ~discard_q & ~branch_i;
  assign push_entry = '{addr: pc_q, insn: insn_data_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr_q  <= {BOOT_ADDR[31:2], 2'b00};
      pc_q          <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      outstanding_q <= handshake;
      discard_q     <= (handshake & branch_i) | (discard_q & ~rsp);
      if (handshake) pc_q <= fetch_addr_q;
      if (branch_i)
        fetch_addr_q <= {branch_addr_i[31:2], 2'b00};
      else if (handshake)
        fetch_addr_q <= fetch_addr_q + 32'(INSN_BYTES);
    end
  end

  catv_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .flush     (branch_i),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign instr_valid_o = ~empty;
  assign instr_rdata_o = empty ? 32'h0 : head.insn;
  assign instr_addr_o  = empty ? 32'h0 : head.addr;
  assign busy_o        = outstanding_q | ~empty;

endmodule
